conv_tap_sequencer: RTL and testbench
=====================================

# conv_tap_sequencer

Parametrised operand sequencer for the Sobel/convolution datapath. It snapshots a KxK pixel window and a KxK signed filter, then issues (coefficient, pixel) pairs one per accepted handshake to the downstream multiply-accumulate. Zero coefficients are skipped, and the filter can be applied directly (X mode) or transposed (Y mode), so one instance serves both gradient directions. It sits between the window buffer and the MAC, replacing the fixed 3x3, fixed-order selectors.

## Interface
- K, default 3: kernel side; taps = K*K, legal range 2..5.
- PIX_W, default 4: unsigned pixel width.
- COEF_W, default 5: two's-complement coefficient width; must be > PIX_W.
- SKIP_ZERO, default 1: 1 skips zero coefficients; 0 issues all K*K taps.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- calc_enable  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = X (coef filter[r][c]), 1 = Y (coef filter[c][r]).
- pixels  in  [K-1:0][K-1:0][PIX_W-1:0]  window, indexed [row][col].
- filter  in  [K-1:0][K-1:0][COEF_W-1:0]  coefficients, indexed [row][col].
- op_ready  in  1  MAC accepts the current operand pair.
- a  out  COEF_W  coefficient.
- b  out  COEF_W  pixel, zero-extended.
- op_valid  out  1  a/b valid.
- op_first  out  1  current pair is the first of the job; MAC clears its accumulator.
- op_last  out  1  current pair is the last of the job.
- calc_done  out  1  one-cycle job-complete pulse.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has states IDLE, ISSUE and DONE. All transitions happen on the rising clock edge.
- IDLE to ISSUE happens on calc_enable=1 when the tap mask is non-zero.
  - On that edge, register pixels, filter and mode.
  - Build the tap mask: bit r*K+c is set if the effective coefficient is non-zero, or unconditionally when SKIP_ZERO=0.
- IDLE to DONE happens on calc_enable=1 when the mask is all zero. No operands are issued, and the MAC accumulator keeps its previous value.
- In ISSUE, the current tap is the lowest set bit of the remaining mask (row-major: r, then c).
  - a = effective coefficient of that tap.
  - b = {zeros, pixel[r][c]}.
  - op_valid = 1.
- On op_valid and op_ready together, clear the current bit.
  - If it was the last bit, go to DONE.
  - Otherwise the next set bit is presented the following cycle.
- op_first is high while the current bit is the lowest bit of the snapshot mask.
- op_last is high while exactly one bit remains. A one-tap job has op_first and op_last both high.
- DONE: calc_done=1 for exactly one cycle, then IDLE.
- calc_enable outside IDLE is ignored. Input changes after the snapshot have no effect on the job.
- Outputs outside ISSUE: a=0, b=0, op_valid=op_first=op_last=0.

## Timing
- Reset values: all outputs 0; state IDLE; mask and snapshot registers 0.
- Reset asserted mid-job forces IDLE immediately. No calc_done is produced and the partial job is discarded.
- Operands are registered-state driven: op_valid rises the cycle after the calc_enable edge.
- With op_ready held high, n issued taps take n cycles. calc_done occurs at cycle n+1 after the enable edge; busy falls at cycle n+2.
- Back-pressure: while op_valid=1 and op_ready=0, a, b, op_first and op_last hold stable and the mask does not change.
- An empty mask gives calc_done one cycle after the enable edge.
- calc_enable held high continuously starts a new job on the first IDLE cycle after DONE.

## Structure
- Shared package conv_pkg holds:
  - the state typedef (IDLE, ISSUE, DONE);
  - the mode enum (MODE_X=0, MODE_Y=1);
  - a mask-width function returning K*K.
- One sub-module, tap_priority_enc (parameter N): returns the lowest-set-bit index and a one-hot/any flag for an N-bit mask. It is instantiated once on the remaining mask.
- Tap decode of index to (r, c) and the coefficient transpose mux are local combinational logic.

## Test plan
All scenarios use K=3 and pixels[r][c] = 3r+c+1, i.e. values 1..9.
- X mode, Gx = [[-1,0,1],[-2,0,2],[-1,0,1]], op_ready=1.
  - Required: 6 pairs, a = 1F,01,1E,02,1F,01 and b = 1,3,4,6,7,9.
  - op_first on pair 1, op_last on pair 6, calc_done at cycle 7.
- Y mode, same filter.
  - Required: a = 1F,1E,1F,01,02,01 and b = 1,2,3,7,8,9.
  - Taps (1,*) are skipped.
- Back-pressure: X mode, op_ready low for 3 cycles on pair 2.
  - Required: a=01, b=3 held stable for those cycles, then the sequence resumes; calc_done is 3 cycles later than in scenario 1.
- All-zero filter: calc_done one cycle after the enable edge with no op_valid. With SKIP_ZERO=0, an all-zero filter yields 9 pairs with a=0.
- Single non-zero tap filter[1][1]=02: one pair, a=02, b=5, with op_first and op_last both high.
- Reset and restart:
  - Pulse n_rst low during pair 3: outputs go to 0 asynchronously, and no calc_done follows.
  - Pulse calc_enable during ISSUE: ignored.
  - calc_enable held high: back-to-back jobs separated by one DONE cycle and one IDLE cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the convolution operand sequencer: FSM states, filter
// orientation and the tap-mask width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_X = 1'b0,
    MODE_Y = 1'b1
  } mode_t;

  function automatic int mask_width(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/tap_priority_enc.sv
// Lowest-set-bit priority encoder over an N-bit tap mask, with "any bit set"
// and "exactly one bit set" flags.
module tap_priority_enc #(
  parameter int N = 9
) (
  input  logic [N-1:0]         mask,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any,
  output logic                 one_hot
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign any     = |mask;
  assign one_hot = any && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/conv_tap_sequencer.sv
// Snapshots a KxK window and filter, then issues non-zero (coef, pixel) pairs
// to the MAC one per handshake, optionally transposing the filter.
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int K         = 3,
  parameter int PIX_W     = 4,
  parameter int COEF_W    = 5,
  parameter int SKIP_ZERO = 1
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                calc_enable,
  input  logic                                mode,
  input  logic [K-1:0][K-1:0][PIX_W-1:0]      pixels,
  input  logic [K-1:0][K-1:0][COEF_W-1:0]     filter,
  input  logic                                op_ready,
  output logic [COEF_W-1:0]                   a,
  output logic [COEF_W-1:0]                   b,
  output logic                                op_valid,
  output logic                                op_first,
  output logic                                op_last,
  output logic                                calc_done,
  output logic                                busy
);

  localparam int N  = mask_width(K);
  localparam int IW = $clog2(N);

  state_t                           state, state_nxt;
  logic [N-1:0]                     mask_q, mask_nxt, new_mask;
  logic                             first_q, first_nxt;
  logic                             start;
  mode_t                            mode_q;
  logic [K-1:0][K-1:0][PIX_W-1:0]   pix_q;
  logic [K-1:0][K-1:0][COEF_W-1:0]  filt_q;
  logic [IW-1:0]                    cur_idx;
  logic                             cur_any, cur_single;
  logic [COEF_W-1:0]                cur_coef;
  logic [PIX_W-1:0]                 cur_pix;

  tap_priority_enc #(.N(N)) u_enc (
    .mask    (mask_q),
    .idx     (cur_idx),
    .any     (cur_any),
    .one_hot (cur_single)
  );

  // Mask is built from the live inputs so it lands together with the snapshot.
  always_comb begin
    new_mask = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (SKIP_ZERO == 0)
          new_mask[r*K+c] = 1'b1;
        else if (mode)
          new_mask[r*K+c] = |filter[c][r];
        else
          new_mask[r*K+c] = |filter[r][c];
      end
    end
  end

  always_comb begin
    cur_coef = '0;
    cur_pix  = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (cur_idx == IW'(r*K+c)) begin
          cur_pix  = pix_q[r][c];
          cur_coef = (mode_q == MODE_Y) ? filt_q[c][r] : filt_q[r][c];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    first_nxt = first_q;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    op_valid  = 1'b0;
    op_first  = 1'b0;
    op_last   = 1'b0;
    case (state)
      IDLE: begin
        if (calc_enable) begin
          start     = 1'b1;
          mask_nxt  = new_mask;
          first_nxt = 1'b1;
          state_nxt = (|new_mask) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        a        = cur_coef;
        b        = {{(COEF_W-PIX_W){1'b0}}, cur_pix};
        op_valid = cur_any;
        op_first = first_q;
        op_last  = cur_single;
        if (op_ready) begin
          mask_nxt[cur_idx] = 1'b0;
          first_nxt         = 1'b0;
          if (cur_single) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign calc_done = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      mask_q  <= '0;
      first_q <= 1'b0;
      mode_q  <= MODE_X;
      pix_q   <= '0;
      filt_q  <= '0;
    end else begin
      state   <= state_nxt;
      mask_q  <= mask_nxt;
      first_q <= first_nxt;
      if (start) begin
        mode_q <= mode_t'(mode);
        pix_q  <= pixels;
        filt_q <= filter;
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed bench for conv_tap_sequencer: scoreboard of expected operand pairs
// checked by a monitor, plus done/busy timing and reset checks.
module tb_conv_tap_sequencer;

  typedef logic [2:0][2:0][4:0] filt_t;
  typedef logic [2:0][2:0][3:0] pix_t;
  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic       first;
    logic       last;
  } pair_t;

  logic       clk;
  logic       n_rst;
  logic       calc_enable, calc_enable2;
  logic       mode;
  pix_t       pixels;
  filt_t      filter;
  logic       op_ready;
  logic [4:0] a, b, a2, b2;
  logic       op_valid, op_first, op_last, calc_done, busy;
  logic       op_valid2, op_first2, op_last2, calc_done2, busy2;

  pair_t      exp_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  pix_t       base_pix;
  filt_t      gx;
  logic [4:0] tx_a[9], ty_a[9], t1_a[9];
  logic [3:0] tx_b[9], ty_b[9], t1_b[9];

  conv_tap_sequencer #(.K(3), .PIX_W(4), .COEF_W(5), .SKIP_ZERO(1)) dut (
    .clk(clk), .n_rst(n_rst), .calc_enable(calc_enable), .mode(mode),
    .pixels(pixels), .filter(filter), .op_ready(op_ready),
    .a(a), .b(b), .op_valid(op_valid), .op_first(op_first), .op_last(op_last),
    .calc_done(calc_done), .busy(busy)
  );

  conv_tap_sequencer #(.K(3), .PIX_W(4), .COEF_W(5), .SKIP_ZERO(0)) dut_all (
    .clk(clk), .n_rst(n_rst), .calc_enable(calc_enable2), .mode(mode),
    .pixels(pixels), .filter(filter), .op_ready(op_ready),
    .a(a2), .b(b2), .op_valid(op_valid2), .op_first(op_first2), .op_last(op_last2),
    .calc_done(calc_done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every presented pair is compared to the queue head; it is retired only on accept.
  always @(negedge clk) begin
    if (op_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pair", 32'(op_valid), 32'd0);
      end else begin
        check_output("pair", 32'(pair_t'({a, b, op_first, op_last})), 32'(exp_q[0]));
        if (op_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_job(input logic [4:0] av[9], input logic [3:0] bv[9], input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: av[i], b: {1'b0, bv[i]}, first: (i == 0), last: (i == n - 1)});
  endtask

  task automatic run_job(input string tag, input int exp_k, input int sf, input int sl,
                         input int en_at, input bit hold, input bit scramble);
    int k;
    int done_k;
    logic [63:0] rnd;
    done_k = -1;
    @(posedge clk); #1;
    calc_enable = hold;
    if (scramble) begin
      rnd    = {$urandom, $urandom};
      pixels = rnd[35:0];
      filter = rnd[44:0];
      mode   = ~mode;
    end
    k = 1;
    op_ready = !(k >= sf && k < sf + sl);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (calc_done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
      k++;
      op_ready    = !(k >= sf && k < sf + sl);
      calc_enable = (k == en_at) ? 1'b1 : hold;
    end
    check_output({tag, "_done_cycle"}, 32'(done_k), 32'(exp_k));
    check_output({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    op_ready = 1'b1;
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 32'(calc_done), 32'd0);
    check_output({tag, "_busy_fall"}, 32'(busy), 32'd0);
    if (!hold) check_output({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_stimulus(input string tag, input logic m, input filt_t f, input int exp_k,
                                input int sf, input int sl, input int en_at, input bit hold,
                                input bit scramble);
    @(posedge clk); #1;
    pixels      = base_pix;
    filter      = f;
    mode        = m;
    calc_enable = 1'b1;
    run_job(tag, exp_k, sf, sl, en_at, hold, scramble);
  endtask

  initial begin
    int dc;
    filt_t f;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        base_pix[r][c] = 4'(3 * r + c + 1);
    gx = '0;
    gx[0][0] = 5'h1F; gx[0][2] = 5'h01;
    gx[1][0] = 5'h1E; gx[1][2] = 5'h02;
    gx[2][0] = 5'h1F; gx[2][2] = 5'h01;
    tx_a = '{5'h1F, 5'h01, 5'h1E, 5'h02, 5'h1F, 5'h01, 5'h00, 5'h00, 5'h00};
    tx_b = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd0, 4'd0, 4'd0};
    ty_a = '{5'h1F, 5'h1E, 5'h1F, 5'h01, 5'h02, 5'h01, 5'h00, 5'h00, 5'h00};
    ty_b = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0};
    t1_a = '{5'h02, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    t1_b = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    n_rst = 1'b0; calc_enable = 1'b0; calc_enable2 = 1'b0; mode = 1'b0;
    pixels = base_pix; filter = '0; op_ready = 1'b1;
    #12;
    check_output("reset_outputs", 32'({a, b, op_valid, op_first, op_last, calc_done, busy}), 32'd0);
    n_rst = 1'b1;

    push_job(tx_a, tx_b, 6);
    apply_stimulus("x_gx", 1'b0, gx, 7, 0, 0, 0, 1'b0, 1'b1);

    push_job(ty_a, ty_b, 6);
    apply_stimulus("y_gx", 1'b1, gx, 7, 0, 0, 0, 1'b0, 1'b1);

    push_job(tx_a, tx_b, 6);
    apply_stimulus("backpressure", 1'b0, gx, 10, 2, 3, 0, 1'b0, 1'b0);

    apply_stimulus("zero_filter", 1'b0, '0, 1, 0, 0, 0, 1'b0, 1'b0);

    f = '0;
    f[1][1] = 5'h02;
    push_job(t1_a, t1_b, 1);
    apply_stimulus("single_tap", 1'b0, f, 2, 0, 0, 0, 1'b0, 1'b0);

    push_job(tx_a, tx_b, 6);
    apply_stimulus("enable_in_issue", 1'b0, gx, 7, 0, 0, 3, 1'b0, 1'b0);

    push_job(tx_a, tx_b, 6);
    push_job(tx_a, tx_b, 6);
    apply_stimulus("held_job1", 1'b0, gx, 7, 0, 0, 0, 1'b1, 1'b0);
    run_job("held_job2", 7, 0, 0, 0, 1'b0, 1'b0);

    // All nine taps with zero coefficient from the non-skipping instance.
    @(posedge clk); #1;
    pixels = base_pix; filter = '0; mode = 1'b0; calc_enable2 = 1'b1;
    @(posedge clk); #1;
    calc_enable2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_output("noskip_pair", 32'({op_valid2, a2, b2, op_first2, op_last2}),
                   32'({1'b1, 5'd0, 5'(k), (k == 1), (k == 9)}));
    end
    @(negedge clk);
    check_output("noskip_done", 32'(calc_done2), 32'd1);

    // Reset while pair 3 is presented.
    push_job(tx_a, tx_b, 6);
    @(posedge clk); #1;
    pixels = base_pix; filter = gx; mode = 1'b0; calc_enable = 1'b1;
    @(posedge clk); #1;
    calc_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_output("async_reset_outputs",
                    32'({a, b, op_valid, op_first, op_last, calc_done, busy}), 32'd0);
    #1 n_rst = 1'b1;
    exp_q.delete();
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      dc += int'(calc_done) + int'(busy);
    end
    check_output("no_done_after_reset", 32'(dc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
